instr_decode_stage: RTL and testbench

Registered, flow-controlled successor to the combinational instruction-field decoder. It accepts one 32-bit MIPS instruction word plus its PC per handshake and splits the word into op/rs/rt/rd/shamt/funct. It also produces a format class, an extended immediate, a jump target and an illegal-opcode flag. The stage sits between fetch and register read, uses valid/ready on both sides, and holds up to two instructions internally so that `in_ready` is a registered signal.

---
 rtl/decode_pkg.sv | 49 ++++
 rtl/instr_fields.sv | 46 ++++
 rtl/instr_decode_stage.sv | 121 ++++++++++++
 tb/tb_instr_decode_stage.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared opcode constants, format encoding and the fixed-width part of a decoded entry
// for the registered MIPS instruction decode stage.
package decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_ADDIU = 6'd9;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_SLTIU = 6'd11;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_XORI  = 6'd14;
  localparam logic [5:0] OP_LUI   = 6'd15;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [1:0] FMT_R   = 2'd0;
  localparam logic [1:0] FMT_I   = 2'd1;
  localparam logic [1:0] FMT_J   = 2'd2;
  localparam logic [1:0] FMT_ILL = 2'd3;

  // Width-independent fields; imm_ext, jtarget and pc ride alongside in the top's entry
  typedef struct packed {
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
    logic [1:0] fmt;
    logic       illegal;
  } decoded_t;

  function automatic logic [1:0] op_fmt(input logic [5:0] op);
    case (op)
      OP_RTYPE:                 op_fmt = FMT_R;
      OP_J, OP_JAL:             op_fmt = FMT_J;
      OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW:
                                op_fmt = FMT_I;
      default:                  op_fmt = FMT_ILL;
    endcase
  endfunction

endpackage

// File: rtl/instr_fields.sv
// Combinational word+PC decoder: raw fields, format class, extended immediate and
// jump target for one instruction.
module instr_fields
  import decode_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32
) (
  input  logic [31:0]       instr,
  input  logic [PC_W-1:0]   pc,
  output decoded_t          fields,
  output logic [DATA_W-1:0] imm_ext,
  output logic [PC_W-1:0]   jtarget
);

  logic [15:0]        imm;
  logic signed [31:0] lui_val;

  always_comb begin
    fields.op      = instr[31:26];
    fields.rs      = instr[25:21];
    fields.rt      = instr[20:16];
    fields.rd      = instr[15:11];
    fields.shamt   = instr[10:6];
    fields.funct   = instr[5:0];
    fields.fmt     = op_fmt(instr[31:26]);
    fields.illegal = (op_fmt(instr[31:26]) == FMT_ILL);
  end

  always_comb begin
    imm     = instr[15:0];
    lui_val = {imm, 16'h0000};
    case (instr[31:26])
      OP_ANDI, OP_ORI, OP_XORI: imm_ext = DATA_W'(imm);
      OP_LUI:                   imm_ext = DATA_W'(lui_val);
      default:                  imm_ext = DATA_W'($signed(imm));
    endcase
  end

  // Upper PC bits come from pc+4 (wrapping); the low 28 bits are the word index.
  always_comb begin
    jtarget       = pc + PC_W'(4);
    jtarget[27:0] = {instr[25:0], 2'b00};
  end

endmodule

// File: rtl/instr_decode_stage.sv
// Registered decode stage with a main entry and one skid entry so in_ready is a flop.
// state | meaning
// EMPTY | no entries held
// ONE   | main entry full
// TWO   | main and skid entries full
module instr_decode_stage
  import decode_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [5:0]        op,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [4:0]        shamt,
  output logic [5:0]        funct,
  output logic [DATA_W-1:0] imm_ext,
  output logic [PC_W-1:0]   jtarget,
  output logic [1:0]        fmt,
  output logic              illegal,
  output logic [PC_W-1:0]   out_pc
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  typedef struct packed {
    decoded_t          fld;
    logic [DATA_W-1:0] imm_ext;
    logic [PC_W-1:0]   jtarget;
    logic [PC_W-1:0]   pc;
  } entry_t;

  logic [1:0] state, state_nxt;
  entry_t     main_q, skid_q, in_entry;
  logic       in_xfer, out_xfer;
  logic       load_main_in, load_main_skid, load_skid;

  instr_fields #(.DATA_W(DATA_W), .PC_W(PC_W)) u_fields (
    .instr   (in_instr),
    .pc      (in_pc),
    .fields  (in_entry.fld),
    .imm_ext (in_entry.imm_ext),
    .jtarget (in_entry.jtarget)
  );
  assign in_entry.pc = in_pc;

  assign out_valid = (state != ST_EMPTY);
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      ST_EMPTY: if (in_xfer) begin
        state_nxt    = ST_ONE;
        load_main_in = 1'b1;
      end
      ST_ONE: begin
        if (in_xfer && out_xfer) begin
          load_main_in = 1'b1;
        end else if (in_xfer) begin
          state_nxt = ST_TWO;
          load_skid = 1'b1;
        end else if (out_xfer) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_TWO: if (out_xfer) begin
        state_nxt      = ST_ONE;
        load_main_skid = 1'b1;
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_EMPTY;
      in_ready <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
    end else if (flush) begin
      state    <= ST_EMPTY;
      in_ready <= 1'b1;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt != ST_TWO);
      if (load_main_in)   main_q <= in_entry;
      if (load_main_skid) main_q <= skid_q;
      if (load_skid)      skid_q <= in_entry;
    end
  end

  assign op      = main_q.fld.op;
  assign rs      = main_q.fld.rs;
  assign rt      = main_q.fld.rt;
  assign rd      = main_q.fld.rd;
  assign shamt   = main_q.fld.shamt;
  assign funct   = main_q.fld.funct;
  assign fmt     = main_q.fld.fmt;
  assign illegal = main_q.fld.illegal;
  assign imm_ext = main_q.imm_ext;
  assign jtarget = main_q.jtarget;
  assign out_pc  = main_q.pc;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed and random checks of instr_decode_stage against a queue-based reference
// that decodes words arithmetically and tracks occupancy.
module tb_instr_decode_stage;

  logic        clk, reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] imm_ext, jtarget, out_pc;
  logic [1:0]  fmt;
  logic        illegal;

  instr_decode_stage #(.DATA_W(32), .PC_W(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .op(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .imm_ext(imm_ext), .jtarget(jtarget), .fmt(fmt), .illegal(illegal), .out_pc(out_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [31:0] imm, jt, pc;
    logic [1:0]  fmt;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   pops   = 0;
  bit   rst_seen = 1'b1;
  bit   last_acc = 1'b0;

  function automatic exp_t model(input logic [31:0] w, input logic [31:0] p);
    exp_t e;
    int   o;
    e.op    = w[31:26];
    e.rs    = w[25:21];
    e.rt    = w[20:16];
    e.rd    = w[15:11];
    e.shamt = w[10:6];
    e.funct = w[5:0];
    o = int'(w[31:26]);
    if (o == 0)                                               e.fmt = 2'd0;
    else if (o == 2 || o == 3)                                e.fmt = 2'd2;
    else if (o == 4 || o == 5 || (o >= 8 && o <= 15) || o == 35 || o == 43) e.fmt = 2'd1;
    else                                                      e.fmt = 2'd3;
    e.ill = (e.fmt == 2'd3);
    if (o >= 12 && o <= 14) e.imm = {16'h0000, w[15:0]};
    else if (o == 15)       e.imm = {w[15:0], 16'h0000};
    else                    e.imm = {{16{w[15]}}, w[15:0]};
    e.jt = ((p + 32'd4) & 32'hF000_0000) | ({6'b0, w[25:0]} << 2);
    e.pc = p;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    exp_t e;
    chk("in_ready", in_ready, rst_seen ? 1'b0 : (q.size() < 2));
    chk("out_valid", out_valid, q.size() > 0);
    if (q.size() > 0 && out_valid) begin
      e = q[0];
      chk("op", op, e.op);         chk("rs", rs, e.rs);
      chk("rt", rt, e.rt);         chk("rd", rd, e.rd);
      chk("shamt", shamt, e.shamt); chk("funct", funct, e.funct);
      chk("imm_ext", imm_ext, e.imm); chk("jtarget", jtarget, e.jt);
      chk("out_pc", out_pc, e.pc); chk("fmt", fmt, e.fmt);
      chk("illegal", illegal, e.ill);
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_out_valid", out_valid, 0); chk("rst_in_ready", in_ready, 0);
    chk("rst_fields", {op, rs, rt, rd, shamt, funct}, 0);
    chk("rst_imm", imm_ext, 0); chk("rst_jt", jtarget, 0); chk("rst_pc", out_pc, 0);
    chk("rst_fmt", fmt, 0);     chk("rst_illegal", illegal, 0);
  endtask

  // Called at a falling edge: drive, note transfers, take the rising edge, update model, check.
  task automatic cyc(input logic iv, input logic [31:0] w, input logic [31:0] p,
                     input logic ordy, input logic fl, input logic rst);
    bit acc, popd;
    in_valid = iv; in_instr = w; in_pc = p; out_ready = ordy; flush = fl; reset = rst;
    acc  = iv & in_ready & ~fl & ~rst;
    popd = out_valid & ordy & ~fl & ~rst;
    @(posedge clk);
    if (rst) begin
      q.delete(); rst_seen = 1'b1;
    end else if (fl) begin
      q.delete(); rst_seen = 1'b0;
    end else begin
      rst_seen = 1'b0;
      if (popd && q.size() > 0) begin void'(q.pop_front()); pops++; end
      if (acc) q.push_back(model(w, p));
    end
    last_acc = acc;
    @(negedge clk);
    check_state();
  endtask

  task automatic send(input logic [31:0] w, input logic [31:0] p);
    cyc(1'b1, w, p, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic idle();
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] words [4];
    logic [5:0]  ops [17];
    logic [31:0] r, w, p;
    int idx, acc_cnt, pop_start;

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    @(negedge clk);
    cyc(1'b0, 0, 0, 0, 0, 1'b1);
    cyc(1'b1, 32'h8E680020, 0, 0, 0, 1'b1);
    check_reset_outputs();
    idle();
    chk("ready_after_reset", in_ready, 1);

    send(32'h8E680020, 32'h0000_1000);
    chk("lw_op", op, 35); chk("lw_rs", rs, 19); chk("lw_rt", rt, 8);
    chk("lw_imm", imm_ext, 32'h20); chk("lw_fmt", fmt, 1);
    send(32'h2008FFFF, 32'h0000_1004);
    chk("addi_imm", imm_ext, 32'hFFFF_FFFF);
    send(32'h3408FFFF, 32'h0000_1008);
    chk("ori_imm", imm_ext, 32'h0000_FFFF);
    send(32'h3C081234, 32'h0000_100C);
    chk("lui_imm", imm_ext, 32'h1234_0000);
    send(32'h08000101, 32'h4000_0000);
    chk("j_fmt", fmt, 2); chk("j_target", jtarget, 32'h4000_0404);
    send(32'h08000101, 32'hFFFF_FFFC);
    chk("j_wrap_target", jtarget, 32'h0000_0404);
    send(32'hFFA5C3D7, 32'h0000_2000);
    chk("ill_fmt", fmt, 3); chk("ill_flag", illegal, 1); chk("ill_rs", rs, 5'h1D);
    idle();
    chk("drained", out_valid, 0);

    // Back-pressure: four adds into an empty stage with out_ready low for three cycles
    for (int i = 0; i < 4; i++) words[i] = 32'h014B4820 + (32'(i) << 11);
    idx = 0; acc_cnt = 0; pop_start = pops;
    for (int k = 0; k < 3; k++) begin
      cyc(idx < 4, (idx < 4) ? words[idx] : 32'h0, 32'h3000 + 32'(idx * 4), 1'b0, 1'b0, 1'b0);
      if (last_acc) begin idx++; acc_cnt++; end
    end
    chk("stall_accepts", acc_cnt, 2);
    chk("stall_in_ready", in_ready, 0);
    for (int k = 0; k < 20 && (idx < 4 || q.size() > 0); k++) begin
      cyc(idx < 4, (idx < 4) ? words[idx] : 32'h0, 32'h3000 + 32'(idx * 4), 1'b1, 1'b0, 1'b0);
      if (last_acc) idx++;
    end
    chk("bp_all_sent", idx, 4);
    chk("bp_all_out", pops - pop_start, 4);

    // Flush while TWO; the word offered with the flush must be dropped
    cyc(1'b1, 32'h8E680020, 32'h5000, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h2008FFFF, 32'h5004, 1'b0, 1'b0, 1'b0);
    chk("pre_flush_two", in_ready, 0);
    cyc(1'b1, 32'h3C081234, 32'h5008, 1'b1, 1'b1, 1'b0);
    chk("flush_out_valid", out_valid, 0); chk("flush_in_ready", in_ready, 1);
    idle();
    chk("flush_word_dropped", out_valid, 0);

    // Reset from TWO
    cyc(1'b1, 32'h014B4820, 32'h6000, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'hFFA5C3D7, 32'h6004, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h08000101, 32'h6008, 1'b1, 1'b0, 1'b1);
    check_reset_outputs();
    idle();
    chk("ready_after_mid_reset", in_ready, 1);

    ops = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd8, 6'd9, 6'd10, 6'd11, 6'd12,
            6'd13, 6'd14, 6'd15, 6'd35, 6'd43, 6'h3F, 6'h11};
    for (int k = 0; k < 400; k++) begin
      r = $urandom;
      w = {ops[$urandom_range(0, 16)], r[25:0]};
      p = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      cyc($urandom_range(0, 3) != 0, w, p, $urandom_range(0, 3) != 0,
          $urandom_range(0, 39) == 0, 1'b0);
    end
    for (int k = 0; k < 4; k++) idle();
    chk("final_empty", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
